cp0_unit: RTL

Coprocessor 0 for the pipelined MIPS core. It consumes the 6-bit hardware interrupt vector {3'b000, interrupt, timer1_IRQ, timer0_IRQ} assembled at the top level, and the synchronous exception codes produced by the pipeline. It decides whether an exception or interrupt is taken and records the state needed for eret. It sits at the M-stage boundary inside the CPU: the pipeline flushes to the handler when Req is high.

---
 rtl/cp0_pkg.sv | 47 ++++
 rtl/cp0_req_arbiter.sv | 33 +++
 rtl/cp0_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
//==============================================================================
// Module      : cp0_pkg
// Description : Shared register numbers, exception codes and field positions
//               for the coprocessor-0 unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cp0_pkg;

   localparam logic [4:0] c_reg_sr    = 5'd12;
   localparam logic [4:0] c_reg_cause = 5'd13;
   localparam logic [4:0] c_reg_epc   = 5'd14;
   localparam logic [4:0] c_reg_prid  = 5'd15;

   localparam logic [4:0] c_exc_int     = 5'd0;
   localparam logic [4:0] c_exc_adel    = 5'd4;
   localparam logic [4:0] c_exc_ades    = 5'd5;
   localparam logic [4:0] c_exc_syscall = 5'd8;
   localparam logic [4:0] c_exc_ri      = 5'd10;
   localparam logic [4:0] c_exc_ov      = 5'd12;

   localparam int c_sr_ie_bit  = 0;
   localparam int c_sr_exl_bit = 1;
   localparam int c_im_lo      = 10;
   localparam int c_im_hi      = 15;
   localparam int c_exc_lo     = 2;
   localparam int c_exc_hi     = 6;
   localparam int c_bd_bit     = 31;

   localparam logic [31:0] c_handler_addr = 32'h0000_4180;

   function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                           input logic exl,
                                           input logic ie);
      return {16'b0, im, 8'b0, exl, ie};
   endfunction

   function automatic logic [31:0] pack_cause(input logic bd,
                                              input logic [5:0] ip,
                                              input logic [4:0] exc_code);
      return {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
   endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_req_arbiter.sv
//==============================================================================
// Module      : cp0_req_arbiter
// Description : Decides whether an interrupt or exception is taken and which
//               ExcCode is recorded; interrupts win over exceptions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cp0_req_arbiter
   import cp0_pkg::*;
(
   input  logic [5:0] hw_int,
   input  logic [5:0] im,
   input  logic       ie,
   input  logic       exl,
   input  logic [4:0] exc_code_in,
   output logic       req,
   output logic [4:0] exc_code
);

   logic w_int_req;
   logic w_exc_req;

   always_comb begin
      w_int_req = ie & ~exl & (|(hw_int & im));
      w_exc_req = ~exl & (exc_code_in != c_exc_int);
      req       = w_int_req | w_exc_req;
      exc_code  = w_int_req ? c_exc_int : exc_code_in;
   end

endmodule

`default_nettype wire

// File: rtl/cp0_unit.sv
//==============================================================================
// Module      : cp0_unit
// Description : Coprocessor 0 (SR, Cause, EPC) with interrupt/exception
//               entry and eret support. Macro CP0_PRID_EN adds PRId (reg 15).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = c_handler_addr
`ifdef CP0_PRID_EN
   ,
   parameter logic [31:0] PRID_VALUE   = 32'h0000_0007
`endif
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] PC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] EPCOut,
   output logic [31:0] DOut,
   output logic [31:0] HandlerPC
);

   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_exc_code;
   logic [31:0] r_epc;

   logic        w_req;
   logic [4:0]  w_exc_code;
   logic        w_wr_sr;
   logic        w_wr_epc;

   cp0_req_arbiter u_arbiter (
      .hw_int      (HWInt),
      .im          (r_im),
      .ie          (r_ie),
      .exl         (r_exl),
      .exc_code_in (ExcCodeIn),
      .req         (w_req),
      .exc_code    (w_exc_code)
   );

   assign w_wr_sr  = WE && (A2 == c_reg_sr);
   assign w_wr_epc = WE && (A2 == c_reg_epc);

   // Exception entry overrides any mtc0 and eret in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_im       <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_ip       <= '0;
         r_exc_code <= '0;
         r_epc      <= '0;
      end else begin
         r_ip <= HWInt;
         if (w_req) begin
            r_exl      <= 1'b1;
            r_exc_code <= w_exc_code;
            r_bd       <= BDIn;
            r_epc      <= BDIn ? (PC - 32'd4) : PC;
         end else begin
            if (w_wr_sr) begin
               r_im  <= DIn[c_im_hi:c_im_lo];
               r_exl <= DIn[c_sr_exl_bit];
               r_ie  <= DIn[c_sr_ie_bit];
            end
            if (w_wr_epc) begin
               r_epc <= {DIn[31:2], 2'b00};
            end
            if (EXLClr) begin
               r_exl <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      DOut = '0;
      case (A1)
         c_reg_sr:    DOut = pack_sr(r_im, r_exl, r_ie);
         c_reg_cause: DOut = pack_cause(r_bd, r_ip, r_exc_code);
         c_reg_epc:   DOut = r_epc;
`ifdef CP0_PRID_EN
         c_reg_prid:  DOut = PRID_VALUE;
`endif
         default:     DOut = '0;
      endcase
   end

   assign Req       = w_req;
   assign EPCOut    = r_epc;
   assign HandlerPC = HANDLER_ADDR;

endmodule

`default_nettype wire
